// File: rtl/fsk_pkg.sv
// Shared constants and state type for the FSK link framers.
package fsk_pkg;

    localparam int   BIT_CYCLES  = 16;
    localparam int   DATA_WIDTH  = 12;
    localparam int   FRAME_BITS  = 13;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    localparam int   CYC_W = $clog2(BIT_CYCLES);
    localparam int   BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/serializer_if.sv
// Parallel-word valid/ready handshake into the serializer.
interface serializer_if;
    import fsk_pkg::*;

    logic [DATA_WIDTH-1:0] TX_Data;
    logic                  TX_Valid;
    logic                  TX_Ready;

    modport master (output TX_Data, output TX_Valid, input TX_Ready);
    modport slave  (input TX_Data, input TX_Valid, output TX_Ready);

endinterface

// File: rtl/serializer_bit_timer.sv
// Per-bit cycle counter: ticks on the last cycle of each bit period.
module bit_timer #(
    parameter int CYCLES = 16,
    parameter int W      = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == W'(CYCLES - 1));

    // Next count: held at zero while disabled or on a load, wraps on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !en_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serializer.sv
// Transmit framer: start bit (0) then DATA_WIDTH bits MSB first, gapless
// back-to-back frames via a one-word holding register.
module serializer
    import fsk_pkg::*;
(
    input  logic         sysclk,
    input  logic         reset,
    serializer_if.slave  tx,
    output logic         serial_out,
    output logic         TX_Status,
    output logic         frame_done
);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  serial_q, serial_d;
    logic                  frame_done_q, frame_done_d;
    logic                  load_s;
    logic                  accept_s;
    logic                  tick_s;

    assign tx.TX_Ready = !hold_valid_q;
    assign accept_s    = tx.TX_Valid && !hold_valid_q;
    assign serial_out  = serial_q;
    assign frame_done  = frame_done_q;
    assign TX_Status   = (state_q != IDLE);

    bit_timer #(
        .CYCLES (BIT_CYCLES),
        .W      (CYC_W)
    ) u_bit_timer (
        .clk_i   (sysclk),
        .rst_i   (reset),
        .clear_i (load_s),
        .en_i    (state_q != IDLE),
        .tick_o  (tick_s)
    );

    // Frame sequencing, shifter and holding-register next state.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        serial_d     = serial_q;
        frame_done_d = 1'b0;
        load_s       = 1'b0;

        case (state_q)
            IDLE: begin
                serial_d = IDLE_LEVEL;
                if (hold_valid_q) begin
                    load_s   = 1'b1;
                    shift_d  = hold_data_q;
                    serial_d = START_LEVEL;
                    state_d  = START;
                end else begin
                    state_d  = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    serial_d  = shift_q[DATA_WIDTH-1];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    state_d   = START;
                end
            end
            DATA: begin
                if (tick_s && (bit_cnt_q == BIT_W'(DATA_WIDTH - 1))) begin
                    frame_done_d = 1'b1;
                    if (hold_valid_q) begin
                        load_s   = 1'b1;
                        shift_d  = hold_data_q;
                        serial_d = START_LEVEL;
                        state_d  = START;
                    end else begin
                        serial_d = IDLE_LEVEL;
                        state_d  = IDLE;
                    end
                end else if (tick_s) begin
                    shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    serial_d  = shift_q[DATA_WIDTH-2];
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end else begin
                    state_d   = DATA;
                end
            end
            default: begin
                serial_d = IDLE_LEVEL;
                state_d  = IDLE;
            end
        endcase

        // A new accept wins over a same-edge reload of the holding register.
        if (accept_s) begin
            hold_data_d  = tx.TX_Data;
            hold_valid_d = 1'b1;
        end else if (load_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            serial_q     <= IDLE_LEVEL;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            serial_q     <= serial_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
